slow_ch_rx: RTL and testbench

//  Receive side of the 16-bit slow channel. Accepts words via srdy/drdy handshake and packs 4 words into one 64-bit word.

---
 rtl/slow_ch_rx.sv | 116 +++++++++++
 tb/tb_slow_ch_rx.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/slow_ch_rx.sv
// slow_ch_rx: receive side of the 16-bit slow channel.
// Packs four 16-bit channel beats into one 64-bit word for the DMA write
// path and flags the word that ends a transfer (disconnect).
//
// Handshakes:
//   Channel side: a beat is transferred on a rising clk edge where
//   p_channel_srdy && p_channel_drdy. p_channel_drdy is a pure register
//   output (!pend_q) with no combinational path from srdy or i_ack.
//   DMA side: a word is transferred on a rising clk edge where
//   o_valid && i_ack. While o_valid && !i_ack, o_data/o_words/o_last hold.
module slow_ch_rx #(
  parameter logic [15:0] PAD_WORD = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p_channel_srdy,
  output logic        p_channel_drdy,
  input  logic        p_channel_disconnect,
  input  logic        p_channel_data_valid,
  input  logic [15:0] p_channel_data,
  output logic        o_valid,
  input  logic        i_ack,
  output logic [63:0] o_data,
  output logic [2:0]  o_words,
  output logic        o_last
);

  // Assembly register: four 16-bit lanes plus the next lane to fill.
  // While pend_q is set it holds the completed word waiting for the
  // output slot, together with hold_words_q / hold_last_q.
  logic [15:0] lane_q [4];
  logic [1:0]  ptr_q;
  logic        pend_q;
  logic [2:0]  hold_words_q;
  logic        hold_last_q;

  // Handshake qualifiers.
  logic        beat;
  logic        slot_free;
  logic        complete;

  // Word as it would look if completed by the current beat.
  logic [15:0] packed_lane [4];
  logic [63:0] packed_data;
  logic [2:0]  packed_words;

  assign p_channel_drdy = !pend_q;
  assign beat           = p_channel_srdy && !pend_q;
  assign slot_free      = !o_valid || i_ack;
  assign complete       = beat &&
                          ((p_channel_data_valid && (ptr_q == 2'd3)) ||
                           p_channel_disconnect);

  // Lanes below ptr come from the register, lane ptr from the live beat
  // (if it carries data), every lane above is padded.
  for (genvar g = 0; g < 4; g++) begin : g_pack
    localparam logic [1:0] LANE = 2'(g);
    assign packed_lane[g] = (LANE < ptr_q) ? lane_q[g] :
                            ((LANE == ptr_q) && p_channel_data_valid) ?
                              p_channel_data : PAD_WORD;
  end

  assign packed_data  = {packed_lane[3], packed_lane[2],
                         packed_lane[1], packed_lane[0]};
  assign packed_words = {1'b0, ptr_q} + {2'b00, p_channel_data_valid};

  // Assembly: fill lanes on data beats; on completion either restart at
  // lane 0 or, if the output slot is busy, park the packed word here.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) lane_q[i] <= 16'h0000;
      ptr_q        <= 2'd0;
      hold_words_q <= 3'd0;
      hold_last_q  <= 1'b0;
    end else if (beat) begin
      if (complete) begin
        ptr_q <= 2'd0;
        if (!slot_free) begin
          for (int i = 0; i < 4; i++) lane_q[i] <= packed_lane[i];
          hold_words_q <= packed_words;
          hold_last_q  <= p_channel_disconnect;
        end
      end else if (p_channel_data_valid) begin
        lane_q[ptr_q] <= p_channel_data;
        ptr_q         <= ptr_q + 2'd1;
      end
    end
  end

  // Output slot: a parked word has priority, then a word completing this
  // edge; otherwise an ack empties the slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_data  <= 64'h0;
      o_words <= 3'd0;
      o_last  <= 1'b0;
      pend_q  <= 1'b0;
    end else if (pend_q && i_ack) begin
      o_valid <= 1'b1;
      o_data  <= {lane_q[3], lane_q[2], lane_q[1], lane_q[0]};
      o_words <= hold_words_q;
      o_last  <= hold_last_q;
      pend_q  <= 1'b0;
    end else if (complete && slot_free) begin
      o_valid <= 1'b1;
      o_data  <= packed_data;
      o_words <= packed_words;
      o_last  <= p_channel_disconnect;
    end else begin
      if (complete) pend_q <= 1'b1;
      if (i_ack) o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_slow_ch_rx.sv
// tb_slow_ch_rx: directed bench for slow_ch_rx with hand-computed words.
module tb_slow_ch_rx;

  localparam logic [15:0] PAD_WORD = 16'h0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p_channel_srdy = 1'b0;
  logic        p_channel_drdy;
  logic        p_channel_disconnect = 1'b0;
  logic        p_channel_data_valid = 1'b0;
  logic [15:0] p_channel_data = 16'h0;
  logic        o_valid;
  logic        i_ack = 1'b0;
  logic [63:0] o_data;
  logic [2:0]  o_words;
  logic        o_last;

  // Expected words: {last, words[2:0], data[63:0]}.
  logic [67:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int stall_cnt = 0;
  int n_words = 0;
  logic        hold_prev = 1'b0;
  logic [63:0] prev_data = 64'h0;
  logic [2:0]  prev_words = 3'd0;

  slow_ch_rx #(.PAD_WORD(PAD_WORD)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .p_channel_srdy       (p_channel_srdy),
    .p_channel_drdy       (p_channel_drdy),
    .p_channel_disconnect (p_channel_disconnect),
    .p_channel_data_valid (p_channel_data_valid),
    .p_channel_data       (p_channel_data),
    .o_valid              (o_valid),
    .i_ack                (i_ack),
    .o_data               (o_data),
    .o_words              (o_words),
    .o_last               (o_last)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_word(input logic last, input logic [2:0] words, input logic [63:0] data);
    exp_q.push_back({last, words, data});
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted; srdy stays high after so
  // consecutive calls stream at one beat per clock.
  task automatic send_beat(input logic [15:0] d, input logic dv, input logic disc);
    logic taken;
    p_channel_srdy       = 1'b1;
    p_channel_data       = d;
    p_channel_data_valid = dv;
    p_channel_disconnect = disc;
    taken = 1'b0;
    for (int c = 0; c < 20 && !taken; c++) begin
      @(negedge clk);
      if (p_channel_drdy) begin
        @(posedge clk);
        #1;
        taken = 1'b1;
      end else begin
        stall_cnt++;
      end
    end
    if (!taken) check("beat_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle();
    p_channel_srdy       = 1'b0;
    p_channel_data_valid = 1'b0;
    p_channel_disconnect = 1'b0;
    p_channel_data       = 16'hDEAD;
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 40) begin
      @(negedge clk);
      c++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    tick(1);
  endtask

  // Scoreboard: every accepted word is compared with the queue head;
  // a word stalled by !i_ack must not change.
  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_data", o_data, prev_data);
        check("hold_words", 64'(o_words), 64'(prev_words));
      end
      if (o_valid && i_ack) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", o_data, 64'hx);
        end else begin
          logic [67:0] e;
          e = exp_q.pop_front();
          check("word_data", o_data, e[63:0]);
          check("word_words", 64'(o_words), 64'(e[66:64]));
          check("word_last", 64'(o_last), 64'(e[67]));
          n_words++;
        end
      end
      hold_prev  = o_valid && !i_ack;
      prev_data  = o_data;
      prev_words = o_words;
    end
  end

  initial begin
    int w0;
    // Reset values.
    tick(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_drdy", 64'(p_channel_drdy), 64'd1);
    check("rst_data", o_data, 64'h0);
    check("rst_words", 64'(o_words), 64'd0);
    check("rst_last", 64'(o_last), 64'd0);
    tick(1);

    // T2: full word, latency 1 after the 4th beat.
    i_ack = 1'b1;
    expect_word(1'b0, 3'd4, 64'h4444_3333_2222_1111);
    send_beat(16'h1111, 1'b1, 1'b0);
    send_beat(16'h2222, 1'b1, 1'b0);
    send_beat(16'h3333, 1'b1, 1'b0);
    send_beat(16'h4444, 1'b1, 1'b0);
    idle();
    @(negedge clk);
    check("t2_latency_valid", 64'(o_valid), 64'd1);
    wait_drain();

    // T1: reset mid-assembly discards the partial word.
    send_beat(16'h5555, 1'b1, 1'b0);
    send_beat(16'h6666, 1'b1, 1'b0);
    idle();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    @(negedge clk);
    check("t1_valid", 64'(o_valid), 64'd0);
    check("t1_drdy", 64'(p_channel_drdy), 64'd1);
    tick(1);
    expect_word(1'b0, 3'd4, 64'hAA04_AA03_AA02_AA01);
    send_beat(16'hAA01, 1'b1, 1'b0);
    send_beat(16'hAA02, 1'b1, 1'b0);
    send_beat(16'hAA03, 1'b1, 1'b0);
    send_beat(16'hAA04, 1'b1, 1'b0);
    idle();
    wait_drain();

    // T3: short word ended by disconnect, then a fresh word from lane 0.
    expect_word(1'b1, 3'd2, 64'h0000_0000_BBBB_AAAA);
    expect_word(1'b0, 3'd4, 64'hFFFF_EEEE_DDDD_CCCC);
    send_beat(16'hAAAA, 1'b1, 1'b0);
    send_beat(16'hBBBB, 1'b1, 1'b1);
    send_beat(16'hCCCC, 1'b1, 1'b0);
    send_beat(16'hDDDD, 1'b1, 1'b0);
    send_beat(16'hEEEE, 1'b1, 1'b0);
    send_beat(16'hFFFF, 1'b1, 1'b0);
    idle();
    wait_drain();

    // T4: backpressure; second word parks and drdy drops.
    i_ack = 1'b0;
    expect_word(1'b0, 3'd4, 64'h1004_1003_1002_1001);
    expect_word(1'b0, 3'd4, 64'h1008_1007_1006_1005);
    for (int k = 1; k <= 8; k++) send_beat(16'h1000 + 16'(k), 1'b1, 1'b0);
    idle();
    @(negedge clk);
    check("t4_drdy_low", 64'(p_channel_drdy), 64'd0);
    check("t4_valid", 64'(o_valid), 64'd1);
    check("t4_first", o_data, 64'h1004_1003_1002_1001);
    tick(1);
    i_ack = 1'b1;
    tick(1);
    i_ack = 1'b0;
    @(negedge clk);
    check("t4_drdy_back", 64'(p_channel_drdy), 64'd1);
    check("t4_valid2", 64'(o_valid), 64'd1);
    check("t4_second", o_data, 64'h1008_1007_1006_1005);
    tick(1);
    i_ack = 1'b1;
    wait_drain();

    // T5: empty beats interleaved, then markers.
    expect_word(1'b0, 3'd4, 64'h4444_3333_2222_1111);
    send_beat(16'h1111, 1'b1, 1'b0);
    send_beat(16'hBAD0, 1'b0, 1'b0);
    send_beat(16'h2222, 1'b1, 1'b0);
    send_beat(16'hBAD1, 1'b0, 1'b0);
    send_beat(16'hBAD2, 1'b0, 1'b0);
    send_beat(16'h3333, 1'b1, 1'b0);
    send_beat(16'hBAD3, 1'b0, 1'b0);
    send_beat(16'h4444, 1'b1, 1'b0);
    idle();
    wait_drain();
    expect_word(1'b1, 3'd0, 64'h0000_0000_0000_0000);
    send_beat(16'h9999, 1'b0, 1'b1);
    idle();
    wait_drain();
    expect_word(1'b1, 3'd2, 64'h0000_0000_5252_5151);
    send_beat(16'h5151, 1'b1, 1'b0);
    send_beat(16'h5252, 1'b1, 1'b0);
    send_beat(16'h7777, 1'b0, 1'b1);
    idle();
    wait_drain();

    // T6: 64 beats streamed at full rate.
    stall_cnt = 0;
    w0 = n_words;
    for (int j = 0; j < 16; j++)
      expect_word(1'b0, 3'd4, {16'(4*j+3), 16'(4*j+2), 16'(4*j+1), 16'(4*j)});
    for (int k = 0; k < 64; k++) send_beat(16'(k), 1'b1, 1'b0);
    idle();
    wait_drain();
    check("t6_stalls", 64'(stall_cnt), 64'd0);
    check("t6_words", 64'(n_words - w0), 64'd16);
    check("final_queue", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
